// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer: issues one instruction-bus
// read per PC, buffers the returned word and reports readiness to flow control.
module pc_fetch #(
    parameter int          CPU_WIDTH  = 32,
    parameter int          FLOW_WIDTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CPU_WIDTH-1:0]  next_pc_i,
    input  logic                  next_pc_four_i,
    input  logic [FLOW_WIDTH-1:0] flow_pc_i,
    output logic                  ibus_req_o,
    output logic [CPU_WIDTH-1:0]  ibus_addr_o,
    input  logic                  ibus_gnt_i,
    input  logic                  ibus_rvalid_i,
    input  logic [31:0]           ibus_rdata_i,
    output logic [CPU_WIDTH-1:0]  pc_o,
    output logic [31:0]           inst_o,
    output logic                  inst_valid_o,
    output logic                  bus_wait_o
);

    localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = FLOW_WIDTH'(0);
    localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = FLOW_WIDTH'(1);
    localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = FLOW_WIDTH'(2);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_READY
    } state_t;

    state_t               state, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d, pc_nxt;
    logic [31:0]          inst_q, inst_d;
    logic                 kill_q, kill_d;
    logic                 req_q;
    logic                 redirect, refresh, grant, rd_outstanding;

    assign pc_nxt   = next_pc_four_i ? pc_q + CPU_WIDTH'(4) : next_pc_i;
    assign redirect = (flow_pc_i == FLOW_WORK) && !next_pc_four_i;
    assign refresh  = (flow_pc_i == FLOW_REFRESH);
    // The request line is registered so it is low during reset; a grant is
    // only meaningful while a request is actually presented.
    assign grant    = ibus_gnt_i && req_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_FETCH;
            pc_q   <= RESET_PC;
            inst_q <= NOP_INST;
            kill_q <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            state  <= state_d;
            pc_q   <= pc_d;
            inst_q <= inst_d;
            kill_q <= kill_d;
            req_q  <= (state_d == S_FETCH);
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state;
        pc_d           = pc_q;
        inst_d         = inst_q;
        kill_d         = kill_q;
        rd_outstanding = 1'b0;

        unique case (state)
            S_FETCH: begin
                if (grant) begin
                    state_d        = S_WAIT;
                    rd_outstanding = 1'b1;
                    if (redirect) begin
                        pc_d   = next_pc_i;
                        kill_d = 1'b1;
                    end
                end else if (redirect) begin
                    pc_d = next_pc_i;
                end
            end
            S_WAIT: begin
                rd_outstanding = !ibus_rvalid_i;
                if (redirect) begin
                    pc_d = next_pc_i;
                    if (ibus_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (ibus_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        inst_d  = ibus_rdata_i;
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (flow_pc_i == FLOW_WORK) begin
                    pc_d    = pc_nxt;
                    inst_d  = NOP_INST;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // A response landing in the same cycle as the refresh has already
        // retired, so only a read still in flight needs to be killed.
        if (refresh) begin
            pc_d   = RESET_PC;
            inst_d = NOP_INST;
            if (rd_outstanding) begin
                kill_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = S_FETCH;
            end
        end
    end

    always_comb begin
        ibus_req_o   = req_q;
        ibus_addr_o  = pc_q;
        pc_o         = pc_q;
        inst_valid_o = (state == S_READY);
        inst_o       = inst_valid_o ? inst_q : NOP_INST;
        bus_wait_o   = !inst_valid_o;
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a bus responder model, a scoreboard of
// expected {pc, instruction} pairs and directed corner-case sequences.
module tb_pc_fetch;

    localparam logic [1:0]  F_WORK    = 2'd0;
    localparam logic [1:0]  F_STOP    = 2'd1;
    localparam logic [1:0]  F_REFRESH = 2'd2;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef struct {
        logic [1:0]  flow;
        logic        four;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc_i;
    logic        next_pc_four_i;
    logic [1:0]  flow_pc_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        bus_wait_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   valid_seen = 1'b0;

    // bus responder model state
    bit          allow_gnt = 1'b1;
    int          lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;

    pc_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc_i      (next_pc_i),
        .next_pc_four_i (next_pc_four_i),
        .flow_pc_i      (flow_pc_i),
        .ibus_req_o     (ibus_req_o),
        .ibus_addr_o    (ibus_addr_o),
        .ibus_gnt_i     (ibus_gnt_i),
        .ibus_rvalid_i  (ibus_rvalid_i),
        .ibus_rdata_i   (ibus_rdata_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o),
        .bus_wait_o     (bus_wait_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] pc);
        sb.push_back('{pc, mem_word(pc)});
    endtask

    // Drive bus inputs for one cycle, advance past the edge, then score any
    // newly valid instruction.
    task automatic step();
        exp_t e;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'hDEAD_BEEF;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                ibus_rvalid_i = 1'b1;
                ibus_rdata_i  = mem_word(pend_addr);
                pend          = 1'b0;
            end
        end
        if (ibus_req_o && allow_gnt && !pend && !rst) begin
            ibus_gnt_i = 1'b1;
            pend       = 1'b1;
            cnt        = lat;
            pend_addr  = ibus_addr_o;
        end
        @(posedge clk);
        #1;
        if (inst_valid_o && !valid_seen) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got valid pc=%h inst=%h expected no instruction", pc_o, inst_o);
            end else begin
                e = sb.pop_front();
                check("sb_pc", pc_o, e.pc);
                check("sb_inst", inst_o, e.inst);
            end
        end
        valid_seen = inst_valid_o;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (inst_valid_o) return;
            step();
        end
        if (!inst_valid_o) begin
            checks++;
            errors++;
            $display("FAIL wait_valid_timeout: got no valid after %0d cycles expected valid", budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(ibus_req_o), 32'd0);
        check({tag, "_pc"}, pc_o, 32'h0);
        check({tag, "_inst"}, inst_o, NOP);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
        check({tag, "_wait"}, 32'(bus_wait_o), 32'd1);
    endtask

    vec_t seq_tab[9];

    initial begin
        seq_tab[0] = '{F_WORK, 1'b1, 1'b1, 32'h0, 1'b0};
        seq_tab[1] = '{F_WORK, 1'b1, 1'b0, 32'h0, 1'b0};
        seq_tab[2] = '{F_WORK, 1'b1, 1'b0, 32'h0, 1'b1};
        seq_tab[3] = '{F_WORK, 1'b1, 1'b1, 32'h4, 1'b0};
        seq_tab[4] = '{F_WORK, 1'b1, 1'b0, 32'h4, 1'b0};
        seq_tab[5] = '{F_WORK, 1'b1, 1'b0, 32'h4, 1'b1};
        seq_tab[6] = '{F_WORK, 1'b1, 1'b1, 32'h8, 1'b0};
        seq_tab[7] = '{F_WORK, 1'b1, 1'b0, 32'h8, 1'b0};
        seq_tab[8] = '{F_WORK, 1'b1, 1'b0, 32'h8, 1'b1};

        rst            = 1'b1;
        next_pc_i      = '0;
        next_pc_four_i = 1'b1;
        flow_pc_i      = F_WORK;
        ibus_gnt_i     = 1'b0;
        ibus_rvalid_i  = 1'b0;
        ibus_rdata_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // sequential fetch from reset: 0, 4, 8 with valid every third cycle
        for (int i = 0; i < 5 && !ibus_req_o; i++) step();
        expect_inst(32'h0);
        expect_inst(32'h4);
        expect_inst(32'h8);
        for (int k = 0; k < 9; k++) begin
            flow_pc_i      = seq_tab[k].flow;
            next_pc_four_i = seq_tab[k].four;
            check($sformatf("seq%0d_req", k), 32'(ibus_req_o), 32'(seq_tab[k].exp_req));
            check($sformatf("seq%0d_addr", k), ibus_addr_o, seq_tab[k].exp_addr);
            check($sformatf("seq%0d_valid", k), 32'(inst_valid_o), 32'(seq_tab[k].exp_valid));
            if (k < 8) step();
        end

        // STOP holds READY with no bus traffic
        flow_pc_i = F_STOP;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stop_pc", pc_o, 32'h8);
            check("stop_inst", inst_o, mem_word(32'h8));
            check("stop_valid", 32'(inst_valid_o), 32'd1);
            check("stop_req", 32'(ibus_req_o), 32'd0);
        end

        // redirect from READY, then PC+4 wraps from the top of memory
        flow_pc_i      = F_WORK;
        next_pc_four_i = 1'b0;
        next_pc_i      = 32'hFFFF_FFFC;
        expect_inst(32'hFFFF_FFFC);
        step();
        next_pc_four_i = 1'b1;
        wait_valid(10);
        expect_inst(32'h0);
        step();
        check("wrap_addr", ibus_addr_o, 32'h0);
        check("wrap_req", 32'(ibus_req_o), 32'd1);
        wait_valid(10);

        // redirect while the request is ungranted moves the address
        allow_gnt = 1'b0;
        step();
        check("nogrant_addr", ibus_addr_o, 32'h4);
        next_pc_four_i = 1'b0;
        next_pc_i      = 32'h300;
        step();
        check("nogrant_redir_addr", ibus_addr_o, 32'h300);
        check("nogrant_redir_req", 32'(ibus_req_o), 32'd1);
        next_pc_four_i = 1'b1;
        allow_gnt      = 1'b1;
        expect_inst(32'h300);
        wait_valid(10);

        // redirect coinciding with grant: old response killed
        step();
        next_pc_four_i = 1'b0;
        next_pc_i      = 32'h200;
        step();
        check("gntredir_addr", ibus_addr_o, 32'h200);
        check("gntredir_req", 32'(ibus_req_o), 32'd0);
        next_pc_four_i = 1'b1;
        expect_inst(32'h200);
        wait_valid(10);

        // redirect in WAIT at 0x10; late response is dropped
        next_pc_four_i = 1'b0;
        next_pc_i      = 32'h10;
        step();
        next_pc_four_i = 1'b1;
        lat            = 3;
        step();
        check("wait_req", 32'(ibus_req_o), 32'd0);
        check("wait_addr", ibus_addr_o, 32'h10);
        next_pc_four_i = 1'b0;
        next_pc_i      = 32'h80;
        step();
        check("waitredir_addr", ibus_addr_o, 32'h80);
        check("waitredir_valid", 32'(inst_valid_o), 32'd0);
        next_pc_four_i = 1'b1;
        expect_inst(32'h80);
        wait_valid(20);

        // REFRESH while a read is in flight
        step();
        step();
        flow_pc_i = F_REFRESH;
        step();
        check("refresh_pc", pc_o, 32'h0);
        check("refresh_req", 32'(ibus_req_o), 32'd0);
        check("refresh_wait", 32'(bus_wait_o), 32'd1);
        flow_pc_i = F_WORK;
        expect_inst(32'h0);
        wait_valid(20);

        // asynchronous reset mid-fetch; stale response arrives in FETCH
        step();
        step();
        check("prerst_addr", ibus_addr_o, 32'h4);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        valid_seen = 1'b0;
        step();
        rst = 1'b0;
        expect_inst(32'h0);
        wait_valid(20);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
